tiny_rv_lsu: RTL and testbench
==============================

Name: tiny_rv_lsu

Overview:
Load/store unit for the tiny_rv execute stage. It sits beside the ALU and takes the same decoded operands (opcode, funct3, rs1, rs2, imm). It computes the effective address, runs a single-beat valid/ready transaction on the data bus, and returns writeback data with byte/halfword alignment and sign extension applied. It is multi-cycle, so the core stalls on o_busy until o_done.

Parameters:
BUS_TIMEOUT, 255, cycles waiting for i_bus_ready before aborting with o_fault; 0 disables the timeout.

Ports:
i_clk  in  1  core clock
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  one-cycle pulse; launches an op when idle
i_opcode  in  7  RV_LOAD or RV_STORE; anything else is ignored
i_funct3  in  3  width/sign: LB=000 LH=001 LW=010 LBU=100 LHU=101 SB=000 SH=001 SW=010
i_rs1  in  32  base address
i_rs2  in  32  store data
i_imm  in  32  sign-extended offset
o_busy  out  1  high from the accepted start until done
o_done  out  1  one-cycle pulse; completion
o_result  out  32  load writeback data, valid while o_done=1
o_misaligned  out  1  qualifies o_done; the op was not issued
o_fault  out  1  qualifies o_done; bus timeout
o_bus_valid  out  1  request valid
i_bus_ready  in  1  request accepted; for reads, i_bus_rdata is valid the same cycle
o_bus_addr  out  32  word-aligned address ({ea[31:2],2'b00})
o_bus_we  out  1  1 = store
o_bus_wstrb  out  4  byte enables
o_bus_wdata  out  32  lane-replicated store data
i_bus_rdata  in  32  read data

Behaviour:
- Reset (sync, i_rst=1 at a rising edge): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction abandons it immediately (o_bus_valid drops the next cycle) and no o_done is produced.
- Effective address: ea = i_rs1 + i_imm, mod 2^32, so wrap-around is silent. It is latched with funct3, opcode and rs2 when a start is accepted.
- Start acceptance: i_start=1 in IDLE with opcode LOAD or STORE.
  - i_start in any other state is ignored.
  - A non-memory opcode or reserved funct3 (011, 110, 111; for stores also 1xx) gives o_done=1 the next cycle with o_result=0 and no bus activity.
- Misalignment: halfword with ea[0]=1, or word with ea[1:0]!=0. Next cycle o_done=1 and o_misaligned=1; the bus is never driven.
- States:
  - IDLE -> REQ on an accepted, aligned start.
  - REQ: o_bus_valid=1; address, we, wstrb and wdata are held stable while valid and ready=0.
    - On i_bus_ready=1: capture rdata -> DONE.
    - On timeout (counter == BUS_TIMEOUT-1 and no ready): -> DONE with fault.
  - DONE: o_done=1 for exactly one cycle, then IDLE. o_bus_valid=0 in DONE.
- Latency: aligned op with ready on the first REQ cycle = start at cycle 0, bus_valid at cycle 1, o_done at cycle 2. Misaligned op = o_done at cycle 1.
- o_busy is 1 in REQ and DONE, and in the cycle after an accepted start; it is 0 in IDLE.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << ea[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << ea[1:0].
  - SW: wdata = rs2, wstrb = 1111.
- Load extract: byte = rdata >> (8*ea[1:0]) [7:0]; half = rdata >> (8*ea[1:0]) [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Stores: o_result=0. Fault: o_result=0, o_fault=1. o_fault and o_misaligned are never both set.
- o_result, o_misaligned and o_fault are 0 whenever o_done=0.

Decomposition:
- Shared tiny_rv package: RV_LOAD/RV_STORE opcode constants; LSU funct3 constants (RV_MEM_B, H, W, BU, HU); lsu_state_t enum {IDLE, REQ, DONE}.
- One natural combinational sub-module, tiny_rv_lsu_align: given ea[1:0], funct3, rs2 and rdata, produce wdata, wstrb, the load result and the misaligned flag. Unit-testable on its own.

Test Plan:
- LW, rs1=0x1000, imm=4, bus ready immediately with rdata=0xDEADBEEF -> bus_addr=0x1004, we=0; o_done at cycle 2 with o_result=0xDEADBEEF.
- LB, rs1=0x2003, imm=0, rdata=0x80123456 -> wstrb unused; o_result=0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH, rs1=0x3000, imm=2, rs2=0x0000ABCD, ready held low 3 cycles -> addr/wdata/wstrb stable for 4 cycles; wdata=0xABCDABCD, wstrb=1100; o_done one cycle after ready.
- LW at ea=0x1002; then SH at ea=0x1001 -> o_done at cycle 1 with o_misaligned=1 for each; o_bus_valid never asserted.
- BUS_TIMEOUT=4, ready never asserted -> exactly 4 REQ cycles, then o_done with o_fault=1 and o_result=0. Also: raise i_rst in the second REQ cycle -> valid=0 the next cycle and no o_done.
- imm=0xFFFFFFFC, rs1=0x00000002 with LW -> ea wraps to 0xFFFFFFFE, flagged misaligned. Also: i_start pulsed while busy -> ignored, and exactly one o_done is seen.

Source files
------------

// File: rtl/tiny_rv_lsu_pkg.sv
// Shared tiny_rv definitions used by the load/store unit: opcode and
// funct3 encodings for memory ops, plus the LSU state enumeration.
package tiny_rv_lsu_pkg;

    localparam logic [6:0] RV_LOAD  = 7'b0000011;
    localparam logic [6:0] RV_STORE = 7'b0100011;

    localparam logic [2:0] RV_MEM_B  = 3'b000;
    localparam logic [2:0] RV_MEM_H  = 3'b001;
    localparam logic [2:0] RV_MEM_W  = 3'b010;
    localparam logic [2:0] RV_MEM_BU = 3'b100;
    localparam logic [2:0] RV_MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/tiny_rv_lsu_if.sv
// Single-beat valid/ready data bus between the LSU (master) and memory (slave).
// Read data is valid in the same cycle that ready is high.
interface tiny_rv_lsu_if;

    logic        o_bus_valid;
    logic        i_bus_ready;
    logic [31:0] o_bus_addr;
    logic        o_bus_we;
    logic [3:0]  o_bus_wstrb;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata;

    modport master (
        output o_bus_valid,
        output o_bus_addr,
        output o_bus_we,
        output o_bus_wstrb,
        output o_bus_wdata,
        input  i_bus_ready,
        input  i_bus_rdata
    );

    modport slave (
        input  o_bus_valid,
        input  o_bus_addr,
        input  o_bus_we,
        input  o_bus_wstrb,
        input  o_bus_wdata,
        output i_bus_ready,
        output i_bus_rdata
    );

endinterface

// File: rtl/tiny_rv_lsu_align.sv
// Byte-lane steering for the LSU: replicates store data across lanes, builds
// byte strobes, extracts and extends load data, and flags misaligned or
// reserved width encodings. Purely combinational.
module tiny_rv_lsu_align
    import tiny_rv_lsu_pkg::*;
(
    input  logic [1:0]  eaLow_i,
    input  logic [2:0]  funct3_i,
    input  logic        isStore_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] loadData_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] laneData;

    // Store side: the bus always sees every lane filled, and the strobes pick
    // which lanes memory actually writes.
    always_comb begin
        wdata_o = rs2_i;
        wstrb_o = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_o = {4{rs2_i[7:0]}};
                wstrb_o = 4'b0001 << eaLow_i;
            end
            2'b01: begin
                wdata_o = {2{rs2_i[15:0]}};
                wstrb_o = 4'b0011 << eaLow_i;
            end
            default: begin
                wdata_o = rs2_i;
                wstrb_o = 4'b1111;
            end
        endcase
    end

    // Load side: shift the addressed lane down to bit 0, then extend by width.
    // Word loads are always aligned here, so the shift is zero for them.
    always_comb begin
        laneData   = rdata_i >> {eaLow_i, 3'b000};
        loadData_o = '0;
        case (funct3_i)
            RV_MEM_B:  loadData_o = {{24{laneData[7]}}, laneData[7:0]};
            RV_MEM_H:  loadData_o = {{16{laneData[15]}}, laneData[15:0]};
            RV_MEM_W:  loadData_o = laneData;
            RV_MEM_BU: loadData_o = {24'd0, laneData[7:0]};
            RV_MEM_HU: loadData_o = {16'd0, laneData[15:0]};
            default:   loadData_o = '0;
        endcase
    end

    // Alignment and encoding checks; stores have no unsigned variants.
    always_comb begin
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned_o = eaLow_i[0];
            2'b10:   misaligned_o = |eaLow_i;
            default: misaligned_o = 1'b0;
        endcase
        illegal_o = (funct3_i[1:0] == 2'b11)
                  || (funct3_i[2] && (isStore_i || funct3_i[1]));
    end

endmodule

// File: rtl/tiny_rv_lsu.sv
// tiny_rv load/store unit. Computes the effective address, issues one bus
// beat, and returns aligned/extended load data. Misaligned or undecodable
// ops complete one cycle after start without touching the bus.
module tiny_rv_lsu
    import tiny_rv_lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_imm,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic        o_misaligned,
    output logic        o_fault,
    tiny_rv_lsu_if.master bus
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(BUS_TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] rs2_q, rs2_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        isStore_q, isStore_d;
    logic [31:0] result_q, result_d;
    logic        misaligned_q, misaligned_d;
    logic        fault_q, fault_d;
    logic [31:0] timeoutCnt_q, timeoutCnt_d;

    logic [31:0] eaLive;
    logic        startIsStore;
    logic        startIsMem;
    logic [1:0]  alignEa;
    logic [2:0]  alignFunct3;
    logic        alignIsStore;
    logic [31:0] alignWdata;
    logic [3:0]  alignWstrb;
    logic [31:0] alignLoad;
    logic        alignMisaligned;
    logic        alignIllegal;
    logic        isReq;
    logic        isDone;

    assign eaLive       = i_rs1 + i_imm;
    assign startIsStore = (i_opcode == RV_STORE);
    assign startIsMem   = (i_opcode == RV_LOAD) || startIsStore;

    // While idle the aligner judges the incoming op so misalignment can be
    // reported the very next cycle; afterwards it works on the latched op.
    assign alignEa      = (state_q == IDLE) ? eaLive[1:0]  : ea_q[1:0];
    assign alignFunct3  = (state_q == IDLE) ? i_funct3     : funct3_q;
    assign alignIsStore = (state_q == IDLE) ? startIsStore : isStore_q;

    tiny_rv_lsu_align u_align (
        .eaLow_i      (alignEa),
        .funct3_i     (alignFunct3),
        .isStore_i    (alignIsStore),
        .rs2_i        (rs2_q),
        .rdata_i      (bus.i_bus_rdata),
        .wdata_o      (alignWdata),
        .wstrb_o      (alignWstrb),
        .loadData_o   (alignLoad),
        .misaligned_o (alignMisaligned),
        .illegal_o    (alignIllegal)
    );

    // State and operand registers; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            ea_q         <= '0;
            rs2_q        <= '0;
            funct3_q     <= '0;
            isStore_q    <= 1'b0;
            result_q     <= '0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            timeoutCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ea_q         <= ea_d;
            rs2_q        <= rs2_d;
            funct3_q     <= funct3_d;
            isStore_q    <= isStore_d;
            result_q     <= result_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for ready (or give up) in REQ,
    // report for a single cycle in DONE.
    always_comb begin
        state_d      = state_q;
        ea_d         = ea_q;
        rs2_d        = rs2_q;
        funct3_d     = funct3_q;
        isStore_d    = isStore_q;
        result_d     = result_q;
        misaligned_d = misaligned_q;
        fault_d      = fault_q;
        timeoutCnt_d = timeoutCnt_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    ea_d         = eaLive;
                    rs2_d        = i_rs2;
                    funct3_d     = i_funct3;
                    isStore_d    = startIsStore;
                    result_d     = '0;
                    misaligned_d = 1'b0;
                    fault_d      = 1'b0;
                    timeoutCnt_d = '0;
                    if (!startIsMem || alignIllegal) begin
                        state_d = DONE;
                    end else if (alignMisaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.i_bus_ready) begin
                    result_d = isStore_q ? '0 : alignLoad;
                    state_d  = DONE;
                end else if ((BUS_TIMEOUT != 0) && (timeoutCnt_q == TIMEOUT_LAST)) begin
                    result_d = '0;
                    fault_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign isReq  = (state_q == REQ);
    assign isDone = (state_q == DONE);

    assign o_busy       = (state_q != IDLE);
    assign o_done       = isDone;
    assign o_result     = isDone ? result_q : '0;
    assign o_misaligned = isDone && misaligned_q;
    assign o_fault      = isDone && fault_q;

    assign bus.o_bus_valid = isReq;
    assign bus.o_bus_addr  = isReq ? {ea_q[31:2], 2'b00} : '0;
    assign bus.o_bus_we    = isReq && isStore_q;
    assign bus.o_bus_wstrb = (isReq && isStore_q) ? alignWstrb : '0;
    assign bus.o_bus_wdata = (isReq && isStore_q) ? alignWdata : '0;

endmodule

// File: tb/tb_tiny_rv_lsu.sv
// Self-checking bench for tiny_rv_lsu. Each op is turned into an expected
// per-cycle output trace from the architectural rules, and a compare process
// checks the DUT against that trace on every cycle.
module tb_tiny_rv_lsu;
    import tiny_rv_lsu_pkg::*;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic        busy;
        logic        valid;
        logic        we;
        logic        chkWrite;
        logic        done;
        logic        misal;
        logic        fault;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
        logic [3:0]  wstrb;
    } expCycle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] imm = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        misaligned;
    logic        fault;

    tiny_rv_lsu_if busIf ();

    tiny_rv_lsu #(.BUS_TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_opcode     (opcode),
        .i_funct3     (funct3),
        .i_rs1        (rs1),
        .i_rs2        (rs2),
        .i_imm        (imm),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result),
        .o_misaligned (misaligned),
        .o_fault      (fault),
        .bus          (busIf.master)
    );

    always #5 clk = ~clk;

    expCycle_t   expQ[$];
    int          checks = 0;
    int          failures = 0;
    int          validCount = 0;
    int          doneCount = 0;
    logic        checkEn = 1'b0;
    logic [31:0] lastAddr = '0;
    logic [31:0] lastWdata = '0;
    logic [3:0]  lastWstrb = '0;
    logic [31:0] lastResult = '0;
    logic        lastMisal = 1'b0;
    logic        lastFault = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
        end
    endtask

    // Cycle-by-cycle compare against the expected trace; an empty trace means idle.
    always @(negedge clk) begin
        expCycle_t e;
        if (checkEn) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
            end else begin
                e = '{default: '0};
            end
            checkOutput("busy", 32'(busy), 32'(e.busy));
            checkOutput("bus_valid", 32'(busIf.o_bus_valid), 32'(e.valid));
            checkOutput("done", 32'(done), 32'(e.done));
            checkOutput("result", result, e.result);
            checkOutput("misaligned", 32'(misaligned), 32'(e.misal));
            checkOutput("fault", 32'(fault), 32'(e.fault));
            if (e.valid) begin
                checkOutput("bus_addr", busIf.o_bus_addr, e.addr);
                checkOutput("bus_we", 32'(busIf.o_bus_we), 32'(e.we));
                if (e.chkWrite) begin
                    checkOutput("bus_wdata", busIf.o_bus_wdata, e.wdata);
                    checkOutput("bus_wstrb", 32'(busIf.o_bus_wstrb), 32'(e.wstrb));
                end
            end
            if (busIf.o_bus_valid) begin
                validCount++;
                lastAddr  = busIf.o_bus_addr;
                lastWdata = busIf.o_bus_wdata;
                lastWstrb = busIf.o_bus_wstrb;
            end
            if (done) begin
                doneCount++;
                lastResult = result;
                lastMisal  = misaligned;
                lastFault  = fault;
            end
        end
    end

    // Launch one op and push its expected trace. readyAt is the REQ cycle index
    // at which memory answers (-1 = never); busyAt re-pulses start at that
    // cycle; rstAt raises reset during that cycle (-1 = none).
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] off, input logic [31:0] rdata,
                                 input int readyAt, input int busyAt, input int rstAt);
        logic [31:0] ea;
        logic [31:0] lane;
        logic [31:0] loadVal;
        int          byteOff;
        int          sizeBytes;
        logic        isStore;
        logic        isMem;
        logic        reserved;
        logic        misal;
        logic        timedOut;
        int          nReq;
        int          lastCycle;
        expCycle_t   e;

        ea        = a + off;
        byteOff   = int'(ea % 4);
        sizeBytes = 1 << f3[1:0];
        isStore   = (op == RV_STORE);
        isMem     = isStore || (op == RV_LOAD);
        reserved  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (isStore && f3 >= 3'd4);
        misal     = (ea % sizeBytes) != 0;

        lane = rdata >> (8 * byteOff);
        case (f3)
            3'b000: begin
                loadVal = lane & 32'hFF;
                if (loadVal >= 128) loadVal = loadVal - 256;
            end
            3'b001: begin
                loadVal = lane & 32'hFFFF;
                if (loadVal >= 32768) loadVal = loadVal - 65536;
            end
            3'b010: loadVal = rdata;
            3'b100: loadVal = lane & 32'hFF;
            3'b101: loadVal = lane & 32'hFFFF;
            default: loadVal = 0;
        endcase

        e = '{default: '0};
        expQ.push_back(e);
        e.busy = 1'b1;
        if (!isMem || reserved) begin
            e.done = 1'b1;
            expQ.push_back(e);
        end else if (misal) begin
            e.done  = 1'b1;
            e.misal = 1'b1;
            expQ.push_back(e);
        end else begin
            timedOut = (readyAt < 0) || (readyAt >= TIMEOUT);
            nReq     = timedOut ? TIMEOUT : readyAt + 1;
            e.valid    = 1'b1;
            e.addr     = ea & ~32'd3;
            e.we       = isStore;
            e.chkWrite = isStore;
            case (sizeBytes)
                1:       e.wdata = (d & 32'hFF) * 32'h01010101;
                2:       e.wdata = (d & 32'hFFFF) * 32'h00010001;
                default: e.wdata = d;
            endcase
            e.wstrb = 4'(((1 << sizeBytes) - 1) << byteOff);
            for (int i = 0; i < nReq; i++) expQ.push_back(e);
            e = '{default: '0};
            e.busy   = 1'b1;
            e.done   = 1'b1;
            e.fault  = timedOut;
            e.result = (timedOut || isStore) ? 32'd0 : loadVal;
            expQ.push_back(e);
        end

        if (rstAt >= 0) begin
            while (expQ.size() > rstAt + 1) void'(expQ.pop_back());
            lastCycle = rstAt + 1;
        end else begin
            lastCycle = expQ.size();
        end

        opcode = op;
        funct3 = f3;
        rs1    = a;
        rs2    = d;
        imm    = off;
        busIf.i_bus_rdata = rdata;
        start  = 1'b1;
        for (int c = 1; c <= lastCycle; c++) begin
            @(posedge clk);
            #1;
            start = (c == busyAt);
            busIf.i_bus_ready = (c == readyAt + 1);
            rst   = (c == rstAt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int doneBefore;
        int validBefore;
        busIf.i_bus_ready = 1'b0;
        busIf.i_bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        checkEn = 1'b1;
        @(posedge clk);
        #1;

        // LW, immediate ready
        applyStimulus(RV_LOAD, RV_MEM_W, 32'h1000, 32'h0, 32'h4, 32'hDEADBEEF, 0, -1, -1);
        checkOutput("lw addr literal", lastAddr, 32'h00001004);
        checkOutput("lw result literal", lastResult, 32'hDEADBEEF);

        // LB / LBU at byte 3
        applyStimulus(RV_LOAD, RV_MEM_B, 32'h2003, 32'h0, 32'h0, 32'h80123456, 0, -1, -1);
        checkOutput("lb result literal", lastResult, 32'hFFFFFF80);
        applyStimulus(RV_LOAD, RV_MEM_BU, 32'h2003, 32'h0, 32'h0, 32'h80123456, 0, -1, -1);
        checkOutput("lbu result literal", lastResult, 32'h00000080);

        // SH with ready held low for three cycles
        validBefore = validCount;
        applyStimulus(RV_STORE, RV_MEM_H, 32'h3000, 32'h0000ABCD, 32'h2, 32'h0, 3, -1, -1);
        checkOutput("sh wdata literal", lastWdata, 32'hABCDABCD);
        checkOutput("sh wstrb literal", 32'(lastWstrb), 32'h0000000C);
        checkOutput("sh valid cycles", 32'(validCount - validBefore), 32'd4);

        // Misaligned LW and SH never touch the bus
        validBefore = validCount;
        applyStimulus(RV_LOAD, RV_MEM_W, 32'h1000, 32'h0, 32'h2, 32'h11111111, 0, -1, -1);
        checkOutput("lw misaligned flag", 32'(lastMisal), 32'd1);
        applyStimulus(RV_STORE, RV_MEM_H, 32'h1001, 32'h5555, 32'h0, 32'h0, 0, -1, -1);
        checkOutput("sh misaligned flag", 32'(lastMisal), 32'd1);
        checkOutput("misaligned bus idle", 32'(validCount - validBefore), 32'd0);

        // Timeout after exactly four REQ cycles
        validBefore = validCount;
        applyStimulus(RV_LOAD, RV_MEM_W, 32'h6000, 32'h0, 32'h0, 32'hCAFEF00D, -1, -1, -1);
        checkOutput("timeout fault", 32'(lastFault), 32'd1);
        checkOutput("timeout result", lastResult, 32'd0);
        checkOutput("timeout req cycles", 32'(validCount - validBefore), 32'd4);

        // Reset in the second REQ cycle drops the op without a done pulse
        doneBefore = doneCount;
        applyStimulus(RV_LOAD, RV_MEM_W, 32'h7000, 32'h0, 32'h0, 32'h0, -1, -1, 2);
        checkOutput("reset no done", 32'(doneCount - doneBefore), 32'd0);

        // Effective address wraps to 0xFFFFFFFE
        applyStimulus(RV_LOAD, RV_MEM_W, 32'h00000002, 32'h0, 32'hFFFFFFFC, 32'h0, 0, -1, -1);
        checkOutput("wrap misaligned", 32'(lastMisal), 32'd1);

        // Start pulses while busy are ignored
        doneBefore = doneCount;
        applyStimulus(RV_LOAD, RV_MEM_H, 32'h4000, 32'h0, 32'h6, 32'h80011234, 1, 3, -1);
        applyStimulus(RV_LOAD, RV_MEM_HU, 32'h4000, 32'h0, 32'h6, 32'h80011234, 1, 1, -1);
        checkOutput("busy start one done each", 32'(doneCount - doneBefore), 32'd2);
        checkOutput("lhu result literal", lastResult, 32'h00008001);

        // More lanes: SB at byte 1, SW, LH at offset 0, LB positive
        applyStimulus(RV_STORE, RV_MEM_B, 32'h5001, 32'h12345678, 32'h0, 32'h0, 0, -1, -1);
        checkOutput("sb wdata literal", lastWdata, 32'h78787878);
        checkOutput("sb wstrb literal", 32'(lastWstrb), 32'h00000002);
        applyStimulus(RV_STORE, RV_MEM_W, 32'h5000, 32'hA5A5F00F, 32'h8, 32'h0, 1, -1, -1);
        applyStimulus(RV_LOAD, RV_MEM_H, 32'h5000, 32'h0, 32'h0, 32'h1234FEDC, 0, -1, -1);
        checkOutput("lh result literal", lastResult, 32'hFFFFFEDC);
        applyStimulus(RV_LOAD, RV_MEM_B, 32'h5000, 32'h0, 32'h1, 32'h00007F00, 2, -1, -1);

        // Reserved store width completes with no flags and no bus beat
        validBefore = validCount;
        applyStimulus(RV_STORE, 3'b100, 32'h5000, 32'h1, 32'h0, 32'h0, 0, -1, -1);
        checkOutput("reserved no bus", 32'(validCount - validBefore), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
